// File: rtl/uart_imem_loader.sv
// Boot loader: parses A5 | N (LE32) | N LE words | sum8 frames popped from the UART RX FIFO
// and writes the words sequentially into instruction memory starting at BASE_ADDR.
module uart_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        ld_en,
  input  logic        rx_data_present,
  input  logic [7:0]  uart_dout,
  output logic        rx_ren,
  output logic        imem_prog_ena,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);
  localparam logic [7:0]    SYNC     = 8'hA5;
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    E_NONE   = 3'd0;
  localparam logic [2:0]    E_LEN    = 3'd1;
  localparam logic [2:0]    E_TMO    = 3'd2;
  localparam logic [2:0]    E_SUM    = 3'd3;
  localparam logic [2:0]    E_ABORT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          rx_ren_q, rx_ren_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          prog_q, prog_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic          in_frame, counting, fail;
  logic [2:0]    fail_code;

  assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) ||
                    (state_q == S_WRITE) || (state_q == S_CHK);
  assign counting = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);

  // A cycle with rx_ren_q high is the cycle the FIFO head is consumed.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    word_d    = word_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = E_NONE;

    if (in_frame && !ld_en) begin
      fail      = 1'b1;
      fail_code = E_ABORT;
    end else begin
      if (rx_ren_q) begin
        tmo_d = TW'(1);
      end else if (counting) begin
        if (tmo_q == TMO_LAST) begin
          fail      = 1'b1;
          fail_code = E_TMO;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (rx_ren_q && uart_dout == SYNC) begin
            state_d = S_LEN;
            bcnt_d  = 2'd0;
            len_d   = 32'd0;
            idx_d   = 32'd0;
            csum_d  = 8'd0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = E_NONE;
          end
        end
        S_LEN: begin
          if (rx_ren_q) begin
            len_d  = {uart_dout, len_q[31:8]};
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (len_d == 32'd0 || len_d > MAX_WORDS) begin
                fail      = 1'b1;
                fail_code = E_LEN;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_ren_q) begin
            word_d = {uart_dout, word_q[31:8]};
            csum_d = csum_q + uart_dout;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          idx_d   = idx_q + 32'd1;
          state_d = (idx_d == len_q) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (rx_ren_q) begin
            if (uart_dout == csum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              fail      = 1'b1;
              fail_code = E_SUM;
            end
          end
        end
        S_DONE, S_ERR: state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
    end

    if (fail) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = fail_code;
    end
  end

  // Outputs are registered from the next state, so they line up with state residency.
  always_comb begin
    prog_d   = (state_d == S_WRITE);
    addr_d   = addr_q;
    din_d    = din_q;
    if (prog_d) begin
      addr_d = BASE_ADDR + (idx_d << 2);
      din_d  = word_d;
    end
    busy_d   = (state_d == S_LEN) || (state_d == S_DATA) ||
               (state_d == S_WRITE) || (state_d == S_CHK);
    rx_ren_d = !rx_ren_q && ld_en && rx_data_present &&
               ((state_d == S_IDLE) || (state_d == S_LEN) ||
                (state_d == S_DATA) || (state_d == S_CHK));
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      rx_ren_q <= 1'b0;
      bcnt_q   <= 2'd0;
      len_q    <= 32'd0;
      word_q   <= 32'd0;
      idx_q    <= 32'd0;
      csum_q   <= 8'd0;
      tmo_q    <= '0;
      prog_q   <= 1'b0;
      addr_q   <= 32'd0;
      din_q    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
    end else begin
      state_q  <= state_d;
      rx_ren_q <= rx_ren_d;
      bcnt_q   <= bcnt_d;
      len_q    <= len_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      prog_q   <= prog_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign rx_ren        = rx_ren_q;
  assign imem_prog_ena = prog_q;
  assign imem_en       = prog_q;
  assign imem_addr     = addr_q;
  assign imem_din      = din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: FIFO model feeding random/directed frames, a byte-position
// frame model predicting outputs every cycle, plus literal checks on key scenarios.
module tb_uart_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int MAXW = 64;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        Rst, ld_en, rx_data_present;
  logic [7:0]  uart_dout;
  logic        rx_ren, imem_prog_ena, imem_en, busy, done, err;
  logic [31:0] imem_addr, imem_din;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  uart_imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .Rst(Rst), .ld_en(ld_en), .rx_data_present(rx_data_present),
    .uart_dout(uart_dout), .rx_ren(rx_ren), .imem_prog_ena(imem_prog_ena),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_din(imem_din), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  int checks = 0, fails = 0, cyc = 0;
  logic [7:0]  rxq[$];
  int          stall = 0, max_stall = 0;
  bit          pop_pending = 0;
  logic [31:0] pay [64];
  logic [31:0] wr_addr_log[$], wr_data_log[$];
  logic [7:0]  nom [15] = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13,
                            8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  // frame model state
  bit          m_in_frame = 0;
  int          m_pos = 0, m_sum = 0, m_idle = 0;
  longint      m_n = 0;
  logic [31:0] m_word = 0;
  bit          e_busy = 0, e_done = 0, e_err = 0, e_we = 0, cur_we = 0;
  logic [2:0]  e_code = 0;
  logic [31:0] e_addr = 0, e_din = 0;
  bit          prev_ren = 0, prev_ld = 0, prev_present = 0, prev_err = 0;
  int          last_pop_cyc = 0, err_rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_pos = 0; m_sum = 0; m_idle = 0; m_n = 0; m_word = 0;
    e_busy = 0; e_done = 0; e_err = 0; e_we = 0; e_code = 0; e_addr = 0; e_din = 0;
  endtask

  task automatic model_fail(input logic [2:0] code);
    e_err = 1; e_code = code; m_in_frame = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int p;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1; m_pos = 0; m_n = 0; m_sum = 0; m_idle = 1;
        e_done = 0; e_err = 0; e_code = 0;
      end
    end else begin
      m_idle = 1;
      if (m_pos < 4) begin
        m_n = m_n + (longint'(b) << (8 * m_pos));
        m_pos++;
        if (m_pos == 4 && (m_n == 0 || m_n > MAXW)) model_fail(3'd1);
      end else begin
        p = m_pos - 4;
        m_pos++;
        if (longint'(p) < 4 * m_n) begin
          m_sum = (m_sum + int'(b)) % 256;
          m_word[8*(p%4) +: 8] = b;
          if (p % 4 == 3) begin
            e_we = 1; e_addr = BASE + 32'(4 * (p / 4)); e_din = m_word;
          end
        end else if (int'(b) == m_sum) begin
          e_done = 1; m_in_frame = 0;
        end else begin
          model_fail(3'd3);
        end
      end
    end
  endtask

  // Compare + model step, once per cycle at the falling edge.
  initial begin
    logic [7:0] head;
    forever begin
      @(negedge clk);
      cyc++;
      if (Rst) begin
        model_reset();
        pop_pending = 0;
        prev_ren = 0; prev_err = 0;
        prev_ld = ld_en; prev_present = rx_data_present;
      end else begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("err_code", 32'(err_code), 32'(e_code));
        chk("prog_ena", 32'(imem_prog_ena), 32'(e_we));
        chk("imem_en", 32'(imem_en), 32'(e_we));
        if (imem_prog_ena) begin
          wr_addr_log.push_back(imem_addr);
          wr_data_log.push_back(imem_din);
        end
        if (e_we) begin
          chk("imem_addr", imem_addr, e_addr);
          chk("imem_din", imem_din, e_din);
        end
        if (rx_ren) begin
          chk("ren_consecutive", 32'(prev_ren), 32'd0);
          chk("ren_with_write", 32'(imem_prog_ena), 32'd0);
          chk("ren_unqualified", 32'(prev_ld && prev_present), 32'd1);
          chk("ren_empty_fifo", 32'(rxq.size() > 0), 32'd1);
        end
        if (err && !prev_err) err_rise_cyc = cyc;
        prev_err = err;

        cur_we = e_we;
        e_we = 0;
        head = (rxq.size() > 0) ? rxq[0] : 8'h00;
        if (m_in_frame && !ld_en) begin
          model_fail(3'd4);
        end else if (rx_ren) begin
          last_pop_cyc = cyc;
          model_byte(head);
        end else if (m_in_frame && !cur_we) begin
          m_idle++;
          if (m_idle == TMO) model_fail(3'd2);
        end
        e_busy = m_in_frame;
        prev_ren = rx_ren; prev_ld = ld_en; prev_present = rx_data_present;
        pop_pending = rx_ren;
      end
    end
  end

  // First-word-fall-through FIFO: pops on the edge that ends an rx_ren cycle.
  initial begin
    rx_data_present = 0;
    uart_dout = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && rxq.size() > 0) begin
        void'(rxq.pop_front());
        stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      end else if (stall > 0) begin
        stall--;
      end
      if (rxq.size() > 0 && stall == 0) begin
        rx_data_present = 1; uart_dout = rxq[0];
      end else begin
        rx_data_present = 0; uart_dout = 8'h00;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic push_frame(input int n, input logic [7:0] cs_xor);
    logic [7:0]  s;
    logic [31:0] w;
    s = 8'h00;
    push(8'hA5);
    w = 32'(n);
    for (int i = 0; i < 4; i++) push(w[8*i +: 8]);
    for (int k = 0; k < n; k++) begin
      w = pay[k];
      for (int i = 0; i < 4; i++) begin
        push(w[8*i +: 8]);
        s = s + w[8*i +: 8];
      end
    end
    push(s ^ cs_xor);
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((rxq.size() != 0 || m_in_frame || busy) && n < 3000);
    chk("idle_budget_expired", 32'(n >= 3000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input int cnt);
    int n;
    n = 0;
    while (wr_addr_log.size() < cnt && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("write_budget_expired", 32'(n >= 1000), 32'd0);
  endtask

  int          n_rand, nb, qs, wc, tries;
  logic [7:0]  x, nz;

  initial begin
    Rst = 1; ld_en = 0;
    repeat (3) @(posedge clk);
    #2 Rst = 0;
    @(negedge clk); #1;
    chk("rst_rx_ren", 32'(rx_ren), 0);
    chk("rst_prog_ena", 32'(imem_prog_ena), 0);
    chk("rst_imem_en", 32'(imem_en), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_din", imem_din, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_code", 32'(err_code), 0);
    repeat (4) @(negedge clk);
    chk("idle_no_pop_when_disabled", 32'(rx_ren), 0);
    @(posedge clk); #2 ld_en = 1;

    // nominal frame preceded by noise bytes 00, FF
    clear_log();
    for (int i = 0; i < 15; i++) push(nom[i]);
    push(8'h4B);
    wait_idle();
    chk("nom_nwrites", 32'(wr_addr_log.size()), 2);
    if (wr_addr_log.size() >= 2) begin
      chk("nom_addr0", wr_addr_log[0], 32'h0000_0100);
      chk("nom_data0", wr_data_log[0], 32'h0000_0013);
      chk("nom_addr1", wr_addr_log[1], 32'h0000_0104);
      chk("nom_data1", wr_data_log[1], 32'hDEAD_BEEF);
    end
    chk("nom_done", 32'(done), 1);
    chk("nom_err", 32'(err), 0);

    // checksum mismatch
    clear_log();
    for (int i = 2; i < 15; i++) push(nom[i]);
    push(8'h4C);
    wait_idle();
    chk("sum_nwrites", 32'(wr_addr_log.size()), 2);
    chk("sum_err", 32'(err), 1);
    chk("sum_code", 32'(err_code), 3);
    chk("sum_done", 32'(done), 0);

    // bad lengths: zero and MAX_WORDS+1
    clear_log();
    push(8'hA5); push(8'h00); push(8'h00); push(8'h00); push(8'h00);
    wait_idle();
    chk("len0_code", 32'(err_code), 1);
    chk("len0_nwrites", 32'(wr_addr_log.size()), 0);
    push(8'hA5); push(8'(MAXW + 1)); push(8'h00); push(8'h00); push(8'h00);
    wait_idle();
    chk("lenmax_code", 32'(err_code), 1);
    chk("lenmax_err", 32'(err), 1);

    // back-to-back frames
    clear_log();
    for (int k = 0; k < 3; k++) pay[k] = $urandom;
    push_frame(3, 8'h00);
    for (int k = 0; k < 2; k++) pay[k] = $urandom;
    push_frame(2, 8'h00);
    wait_idle();
    chk("b2b_nwrites", 32'(wr_addr_log.size()), 5);
    if (wr_addr_log.size() >= 5) chk("b2b_restart_addr", wr_addr_log[3], 32'h0000_0100);
    chk("b2b_done", 32'(done), 1);

    // randomized frames with noise, stalls and occasional bad checksums
    max_stall = 4;
    for (int f = 0; f < 12; f++) begin
      clear_log();
      n_rand = $urandom_range(1, 6);
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      nb = $urandom_range(0, 2);
      for (int i = 0; i < nb; i++) begin
        nz = 8'($urandom_range(0, 255));
        push((nz == 8'hA5) ? 8'h00 : nz);
      end
      for (int k = 0; k < n_rand; k++) pay[k] = $urandom;
      push_frame(n_rand, x);
      wait_idle();
      chk("rand_nwrites", 32'(wr_addr_log.size()), 32'(n_rand));
      chk("rand_done", 32'(done), 32'(x == 8'h00));
      chk("rand_code", 32'(err_code), (x == 8'h00) ? 32'd0 : 32'd3);
    end
    max_stall = 0;

    // timeout: stop after 6 payload bytes
    clear_log();
    push(8'hA5); push(8'h02); push(8'h00); push(8'h00); push(8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55); push(8'h66);
    tries = 0;
    while (!(err && m_pos >= 10) && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    chk("tmo_budget_expired", 32'(tries >= 300), 0);
    repeat (2) @(negedge clk);
    chk("tmo_code", 32'(err_code), 2);
    chk("tmo_latency", 32'(err_rise_cyc - last_pop_cyc), 32'(TMO));
    chk("tmo_nwrites", 32'(wr_addr_log.size()), 1);
    if (wr_data_log.size() >= 1) chk("tmo_data0", wr_data_log[0], 32'h4433_2211);
    chk("tmo_busy", 32'(busy), 0);

    // abort by dropping ld_en mid-DATA
    clear_log();
    for (int k = 0; k < 4; k++) pay[k] = $urandom;
    push_frame(4, 8'h00);
    wait_writes(1);
    repeat (3) @(posedge clk);
    #2 ld_en = 0;
    repeat (2) @(negedge clk);
    qs = rxq.size();
    wc = wr_addr_log.size();
    repeat (25) @(negedge clk);
    chk("abort_code", 32'(err_code), 4);
    chk("abort_err", 32'(err), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_more_writes", 32'(wr_addr_log.size()), 32'(wc));
    chk("abort_fifo_untouched", 32'(rxq.size()), 32'(qs));
    rxq.delete();
    repeat (2) @(posedge clk);
    #2 ld_en = 1;

    // asynchronous reset mid-DATA
    clear_log();
    for (int k = 0; k < 3; k++) pay[k] = $urandom;
    push_frame(3, 8'h00);
    wait_writes(1);
    repeat (2) @(posedge clk);
    #2 Rst = 1;
    #1;
    chk("arst_rx_ren", 32'(rx_ren), 0);
    chk("arst_prog_ena", 32'(imem_prog_ena), 0);
    chk("arst_imem_en", 32'(imem_en), 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_din", imem_din, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_code", 32'(err_code), 0);
    rxq.delete();
    repeat (2) @(posedge clk);
    #2 Rst = 0;

    // recovery after reset, with stalls
    max_stall = 3;
    clear_log();
    for (int i = 2; i < 15; i++) push(nom[i]);
    push(8'h4B);
    wait_idle();
    chk("recover_done", 32'(done), 1);
    chk("recover_nwrites", 32'(wr_addr_log.size()), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Boot loader stage between the UART controller's receive FIFO and the instruction-memory programming port of the memory controller. When enabled, it consumes framed bytes from the UART, assembles 32-bit little-endian words, and writes them sequentially into instruction memory. It holds the core off the bus while a frame is in flight and reports completion or a classified error.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- MAX_WORDS, 16384, largest accepted word count
- TIMEOUT, 50_000_000, maximum idle cycles between bytes inside a frame (≥2)

Ports:
- clk  in  1  system clock; the only clock
- Rst  in  1  reset, asynchronous and active-high
- ld_en  in  1  loader enable, level
- rx_data_present  in  1  UART RX FIFO non-empty
- uart_dout  in  8  RX FIFO head byte, first-word-fall-through, valid while rx_data_present=1
- rx_ren  out  1  one-cycle pop of the RX FIFO
- imem_prog_ena  out  1  instruction-memory write strobe
- imem_en  out  1  instruction-memory enable, same cycle as imem_prog_ena
- imem_addr  out  32  write byte address
- imem_din  out  32  write data
- busy  out  1  frame in progress; drives the core hold
- done  out  1  sticky: last frame loaded and checksum matched
- err  out  1  sticky: last frame failed
- err_code  out  3  0 none, 1 bad length, 2 timeout, 3 checksum, 4 aborted

## Operation
- Frame format: sync byte 0xA5, then 4 bytes of word count N (LE), then 4N payload bytes (each word LE), then 1 checksum byte.
- Checksum: 8-bit sum mod 256 of the payload bytes only. Sync and length bytes are excluded.
- Byte accept: rx_ren=1 for exactly one cycle when rx_data_present=1, ld_en=1, and the state accepts a byte. uart_dout is captured in that same cycle. rx_ren is forced to 0 in the following cycle, so at most one byte is accepted per 2 cycles.
- States and transitions:
  - IDLE: accepts bytes. 0xA5 goes to LEN, clears done/err/err_code, zeroes the word index, byte counter, and checksum. Any other byte is popped and discarded.
  - LEN: collects 4 bytes. If N==0 or N>MAX_WORDS, go to ERR with code 1. Otherwise go to DATA.
  - DATA: collects 4 bytes into a shift register and adds each to the checksum. The 4th byte goes to WRITE.
  - WRITE: one cycle. imem_prog_ena=imem_en=1, imem_addr=BASE_ADDR+(index<<2), imem_din=assembled word. Index increments. If index+1==N go to CHK, else DATA.
  - CHK: one byte. Match goes to DONE, mismatch goes to ERR with code 3.
  - DONE: done=1 for 1 cycle of state residency, then IDLE; the flag stays set.
  - ERR: err=1, then IDLE; the flag and code stay set.
- busy=1 in LEN, DATA, WRITE, CHK. busy=0 otherwise.
- Timeout: a counter resets on each accepted byte and counts in LEN, DATA, CHK. When it reaches TIMEOUT, go to ERR with code 2.
- ld_en falling while busy: next cycle go to ERR with code 4. No further imem writes. Words already written remain in memory.
- ld_en=0 in IDLE: rx_ren stays 0 and the FIFO is untouched.
- Address arithmetic is 32-bit and wraps modulo 2^32, with no check.

## Timing
- Reset values: rx_ren=0, imem_prog_ena=0, imem_en=0, imem_addr=0, imem_din=0, busy=0, done=0, err=0, err_code=0, state=IDLE. All counters and the checksum are 0.
- Rst mid-frame: immediate return to IDLE with the reset values above; any partial word is discarded.
- All outputs are registered.
- Write latency: imem_prog_ena asserts the cycle after the rx_ren that popped the word's 4th byte.
- busy rises the cycle after the sync byte's rx_ren. It falls on the cycle DONE or ERR is entered.
- done/err assert on the cycle after the final checksum or error-causing pop (or on timeout expiry).
- The write strobe never coincides with rx_ren.

## Test plan
- Nominal load: 0xA5, 02 00 00 00, 13 00 00 00, EF BE AD DE, 4B with bytes always present → two writes (addr 0x0 data 0x00000013, addr 0x4 data 0xDEADBEEF); done=1, err=0; rx_ren never high on consecutive cycles.
- Checksum mismatch: same frame with final byte 0x4C → both writes occur; err=1, err_code=3, done=0.
- Bad length: 0xA5, 00 00 00 00 → no writes, err_code=1. Also N=MAX_WORDS+1 → err_code=1.
- Timeout with TIMEOUT=20: stop after 6 payload bytes → one write occurs; err_code=2 exactly 20 cycles after the last rx_ren; busy=0.
- Noise and abort: bytes 0x00, 0xFF before 0xA5 are popped with no state change. Drop ld_en mid-DATA → err_code=4 and no further writes. Assert Rst mid-DATA → all outputs 0 in the same cycle.
- Back-to-back frames: second frame with BASE_ADDR=0x100 → the second sync clears done; addresses restart at 0x100.
